pipe_imem_loader: RTL and testbench
===================================

// Module: pipe_imem_loader
// PURPOSE
//  Sequences program download into the 64-word instruction RAM of the pipelined CPU.
//  - Owns the RAM write port and holds the CPU frozen while loading.
//  - Accepts a word stream over a valid/ready handshake and writes it from word address 0 upward.
//  - Releases the CPU with a one-cycle start pulse once the last write has landed.
// PARAMETERS
//  AW        6  word-address width; RAM depth = 2**AW words
//  DW        32 instruction word width
//  FLUSH_CYC 2  cycles spent in FLUSH after the last accepted word (>=1)
//  BOOT_RUN  0  1: leave reset in RUN (CPU free-running on preloaded RAM); 0: leave reset in IDLE
// PORTS
//  clk       in  1    clock; all logic on posedge
//  rst       in  1    synchronous reset, active-high
//  load_req  in  1    start a download; sampled in IDLE and RUN only
//  ld_valid  in  1    stream word valid
//  ld_data   in  DW   stream word
//  ld_last   in  1    qualifies the final word; valid only with ld_valid
//  ld_ready  out 1    loader accepts a word; a handshake is ld_valid & ld_ready
//  we        out 1    RAM write enable
//  waddr     out AW   RAM word address
//  wdata     out DW   RAM write data
//  cpu_hold  out 1    1 = CPU pipeline frozen / held at PC 0
//  cpu_start out 1    one-cycle pulse when the CPU is released
//  busy      out 1    state is LOAD or FLUSH
//  done      out 1    sticky: last load succeeded; cleared by the next accepted load_req
//  err       out 1    sticky: overflow in the last load; cleared by the next accepted load_req
//  word_cnt  out AW+1 words written in the current or last load; saturates at 2**AW
//  checksum  out 32   sum mod 2**32 of written words
// BEHAVIOUR
//  Outputs and reset
//  - All outputs are registered.
//  - On rst: we=0, waddr=0, wdata=0, ld_ready=0, cpu_start=0, busy=0, done=0, err=0, word_cnt=0, checksum=0.
//  - On rst with BOOT_RUN=0: state IDLE, cpu_hold=1. With BOOT_RUN=1: state RUN, cpu_hold=0.
//  - Reset mid-load abandons the load. Partially written RAM contents are unspecified.
//  FSM: IDLE, LOAD, FLUSH, RUN
//  - IDLE:
//    - cpu_hold=1, ld_ready=0.
//    - load_req -> LOAD. Clears word_cnt, checksum, done and err.
//  - LOAD:
//    - ld_ready=1 for every cycle in LOAD, including the first.
//    - A handshake in cycle n with word_cnt < 2**AW: cycle n+1 has we=1, waddr=word_cnt[AW-1:0], wdata=ld_data.
//      word_cnt increments and checksum += ld_data.
//    - A handshake with word_cnt == 2**AW is an overflow word: accepted and discarded (no we, no checksum update). err is set.
//    - A handshake with ld_last=1 -> FLUSH. ld_last on the first word gives a 1-word program.
//    - ld_valid gaps are allowed. waddr stays contiguous with no skips.
//    - load_req is ignored in LOAD.
//  - FLUSH:
//    - ld_ready=0, we=0.
//    - Stays FLUSH_CYC cycles, then:
//      - err=0: -> RUN, with done=1, cpu_start=1 and cpu_hold=0 in the first RUN cycle.
//      - err=1: -> IDLE, done=0, no cpu_start.
//    - load_req is ignored in FLUSH.
//  - RUN:
//    - cpu_hold=0, ld_ready=0.
//    - load_req -> LOAD. cpu_hold=1 from the next cycle. Counters, done and err are cleared as in IDLE.
//  Timing and hold rules
//  - Timing: last handshake in cycle n -> FLUSH in cycles n+1..n+FLUSH_CYC -> RUN and cpu_start in cycle n+FLUSH_CYC+1.
//  - cpu_hold is 1 in every cycle the state is not RUN.
// TESTING
//  T1 rst held 2 cycles, BOOT_RUN=0 -> cpu_hold=1; all other outputs 0; ld_ready stays 0 with ld_valid=1.
//  T2 load_req; stream 3c010000, 34240050, 0c00001b back-to-back, last on 3rd
//     -> we in 3 consecutive cycles at waddr 0, 1, 2; word_cnt=3; checksum=7c25006b;
//        cpu_start is a single pulse 3 cycles (FLUSH_CYC+1) after the 3rd handshake; done=1.
//  T3 35 words with ld_valid toggled pseudo-randomly -> waddr 0..34 with no gaps or repeats; word_cnt=35; done=1.
//  T4 66 words, last on the 66th -> we exactly 64 times; err=1, word_cnt=64; FSM returns to IDLE;
//     no cpu_start; cpu_hold stays 1.
//  T5 in RUN, pulse load_req -> cpu_hold=1 the next cycle; done=0, word_cnt=0; a new 1-word load completes normally.
//  T6 rst asserted after 10 handshakes -> IDLE next cycle; we=0, word_cnt=0, busy=0; further ld_valid is not accepted.

Source files
------------

// File: rtl/pipe_imem_loader.sv
// Purpose  : sequences a program download into the CPU instruction RAM, holding the CPU until the image has landed.
// Latency  : a word accepted in cycle n is written in cycle n+1; cpu_start fires FLUSH_CYC+1 cycles after the last word.
// Backpress: ld_ready is high for every LOAD cycle and low in all other states; overflow words are accepted and dropped.
module pipe_imem_loader #(
    parameter int AW        = 6,
    parameter int DW        = 32,
    parameter int FLUSH_CYC = 2,
    parameter int BOOT_RUN  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          cpu_hold,
    output logic          cpu_start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_cnt,
    output logic [31:0]   checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Flush counter runs 0..FLUSH_CYC-1; keep at least one bit.
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [AW:0]   DEPTH      = {1'b1, {AW{1'b0}}};
    localparam state_t        RST_STATE  = (BOOT_RUN != 0) ? RUN : IDLE;

    state_t        state, state_nxt;
    logic [FW-1:0] flush_cnt, flush_cnt_nxt;

    logic          hs;
    logic [31:0]   data_ext;

    logic          ld_ready_nxt;
    logic          we_nxt;
    logic [AW-1:0] waddr_nxt;
    logic [DW-1:0] wdata_nxt;
    logic          cpu_hold_nxt;
    logic          cpu_start_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          err_nxt;
    logic [AW:0]   word_cnt_nxt;
    logic [31:0]   checksum_nxt;

    assign hs       = ld_valid & ld_ready;
    assign data_ext = 32'(ld_data);

    // State and flush-timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_STATE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Next-state decode plus the next value of every registered output.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        we_nxt        = 1'b0;
        waddr_nxt     = waddr;
        wdata_nxt     = wdata;
        cpu_start_nxt = 1'b0;
        done_nxt      = done;
        err_nxt       = err;
        word_cnt_nxt  = word_cnt;
        checksum_nxt  = checksum;

        case (state)
            IDLE, RUN: begin
                // A new download wipes the status of the previous one.
                if (load_req) begin
                    state_nxt    = LOAD;
                    word_cnt_nxt = '0;
                    checksum_nxt = '0;
                    done_nxt     = 1'b0;
                    err_nxt      = 1'b0;
                end
            end

            LOAD: begin
                if (hs) begin
                    if (word_cnt < DEPTH) begin
                        we_nxt       = 1'b1;
                        waddr_nxt    = word_cnt[AW-1:0];
                        wdata_nxt    = ld_data;
                        word_cnt_nxt = word_cnt + (AW+1)'(1);
                        checksum_nxt = checksum + data_ext;
                    end else begin
                        // RAM is full: swallow the word so the stream still drains.
                        err_nxt = 1'b1;
                    end
                    if (ld_last) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = '0;
                    end
                end
            end

            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    if (err) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b0;
                    end else begin
                        state_nxt     = RUN;
                        done_nxt      = 1'b1;
                        cpu_start_nxt = 1'b1;
                    end
                end else begin
                    flush_cnt_nxt = flush_cnt + FW'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase

        // State-derived outputs follow the state they will be presented with.
        ld_ready_nxt = (state_nxt == LOAD);
        cpu_hold_nxt = (state_nxt != RUN);
        busy_nxt     = (state_nxt == LOAD) || (state_nxt == FLUSH);
    end

    // Output registers; reset forces the quiet values and abandons any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_ready  <= 1'b0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            cpu_hold  <= (BOOT_RUN == 0);
            cpu_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            word_cnt  <= '0;
            checksum  <= '0;
        end else begin
            ld_ready  <= ld_ready_nxt;
            we        <= we_nxt;
            waddr     <= waddr_nxt;
            wdata     <= wdata_nxt;
            cpu_hold  <= cpu_hold_nxt;
            cpu_start <= cpu_start_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            word_cnt  <= word_cnt_nxt;
            checksum  <= checksum_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_imem_loader.sv
// Purpose  : randomized self-checking bench for pipe_imem_loader against a queue-based download model.
// Latency  : inputs are driven and outputs sampled on the falling edge, one full cycle per step.
// Backpress: the stream toggles ld_valid randomly; ld_ready is only ever observed, never assumed.
module tb_pipe_imem_loader;

    localparam int AW        = 6;
    localparam int DW        = 32;
    localparam int FLUSH_CYC = 2;
    localparam int DEPTH     = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          cpu_hold;
    logic          cpu_start;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;
    logic [31:0]   checksum;

    pipe_imem_loader #(
        .AW(AW), .DW(DW), .FLUSH_CYC(FLUSH_CYC), .BOOT_RUN(0)
    ) dut (
        .clk(clk), .rst(rst), .load_req(load_req),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .busy(busy),
        .done(done), .err(err), .word_cnt(word_cnt), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Download model: what the RAM should see and what the status should read.
    int          m_cnt;
    logic [31:0] m_sum;
    bit          m_err;
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] stim[0:127];

    int n_we     = 0;
    int n_start  = 0;
    int wr_first = -1;
    int wr_last  = -1;

    task automatic accept(input logic [31:0] d);
        if (m_cnt < DEPTH) begin
            exp_addr_q.push_back(m_cnt);
            exp_data_q.push_back(d);
            m_sum = m_sum + d;
            m_cnt++;
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Write-port and start-pulse monitor.
    always @(negedge clk) begin
        if (cpu_start) n_start++;
        if (we) begin
            n_we++;
            if (wr_first < 0) wr_first = cyc;
            wr_last = cyc;
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                chk("waddr", 64'(waddr), 64'(exp_addr_q.pop_front()));
                chk("wdata", wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic do_load_req();
        @(negedge clk);
        load_req = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        m_cnt    = 0;
        m_sum    = '0;
        m_err    = 1'b0;
        wr_first = -1;
        wr_last  = -1;
        @(negedge clk);
        load_req = 1'b0;
        chk("ready_first", ld_ready, 1);
        chk("busy_load", busy, 1);
        chk("hold_load", cpu_hold, 1);
        chk("done_clr", done, 0);
        chk("err_clr", err, 0);
        chk("cnt_clr", word_cnt, 0);
        chk("sum_clr", checksum, 0);
    endtask

    task automatic send_words(input int n, input int gap_pct, input bit with_last, output int last_cyc);
        int sent  = 0;
        int guard = 0;
        bit v;
        last_cyc = 0;
        while (sent < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            chk("ready_in_load", ld_ready, 1);
            chk("hold_in_load", cpu_hold, 1);
            v        = ($urandom_range(99) >= gap_pct);
            load_req = ($urandom_range(3) == 0);
            ld_valid = v;
            ld_data  = v ? stim[sent] : $urandom;
            ld_last  = v && with_last && (sent == n - 1);
            if (v && ld_ready) begin
                accept(stim[sent]);
                sent++;
                last_cyc = cyc;
            end
        end
        if (sent < n) chk("send_timeout", sent, n);
    endtask

    task automatic finish_load(input int last_cyc, input int we_before, input int start_before);
        int target = last_cyc + FLUSH_CYC + 1;
        int guard  = 0;
        bit ok     = !m_err;
        while (cyc < target && guard < 50) begin
            @(negedge clk);
            guard++;
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            load_req = (cyc < target) ? ($urandom_range(1) == 1) : 1'b0;
            if (cyc < target) begin
                chk("busy_flush", busy, 1);
                chk("ready_flush", ld_ready, 0);
                chk("hold_flush", cpu_hold, 1);
                chk("start_early", cpu_start, 0);
            end
        end
        chk("start_pulse", cpu_start, ok);
        chk("hold_after", cpu_hold, !ok);
        chk("done", done, ok);
        chk("err", err, m_err);
        chk("busy_after", busy, 0);
        chk("word_cnt", word_cnt, m_cnt);
        chk("checksum", checksum, m_sum);
        chk("pending_writes", exp_addr_q.size(), 0);
        chk("we_count", n_we - we_before, m_cnt);
        @(negedge clk);
        chk("start_single", cpu_start, 0);
        chk("start_count", n_start - start_before, ok);
        chk("hold_steady", cpu_hold, !ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc, web, stb;
        rst      = 1'b1;
        load_req = 1'b0;
        ld_valid = 1'b1;
        ld_data  = '0;
        ld_last  = 1'b0;
        m_cnt    = 0;
        m_sum    = '0;
        m_err    = 1'b0;

        // T1: reset values, stream ignored while not loading.
        repeat (2) @(negedge clk);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_ready", ld_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_start", cpu_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", word_cnt, 0);
        chk("rst_sum", checksum, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", ld_ready, 0);
            chk("idle_we", we, 0);
            chk("idle_hold", cpu_hold, 1);
        end
        ld_valid = 1'b0;

        // T2: fixed three-word program, back-to-back.
        stim[0] = 32'h3c010000;
        stim[1] = 32'h34240050;
        stim[2] = 32'h0c00001b;
        web = n_we; stb = n_start;
        do_load_req();
        send_words(3, 0, 1'b1, lc);
        finish_load(lc, web, stb);
        chk("t2_checksum", checksum, 32'h7c25006b);
        chk("t2_cnt", word_cnt, 3);
        chk("t2_consecutive", wr_last - wr_first, 2);

        // T3: 35 random words with random valid gaps, launched from RUN.
        for (int i = 0; i < 128; i++) stim[i] = $urandom;
        web = n_we; stb = n_start;
        do_load_req();
        send_words(35, 40, 1'b1, lc);
        finish_load(lc, web, stb);

        // T5: reload from RUN with a single-word program.
        for (int i = 0; i < 128; i++) stim[i] = $urandom;
        web = n_we; stb = n_start;
        do_load_req();
        send_words(1, 0, 1'b1, lc);
        finish_load(lc, web, stb);

        // T4: 66 words overflow a 64-word RAM.
        for (int i = 0; i < 128; i++) stim[i] = $urandom;
        web = n_we; stb = n_start;
        do_load_req();
        send_words(66, 20, 1'b1, lc);
        finish_load(lc, web, stb);
        repeat (4) begin
            @(negedge clk);
            chk("ovf_idle_hold", cpu_hold, 1);
            chk("ovf_idle_ready", ld_ready, 0);
        end

        // T6: reset in the middle of a load.
        for (int i = 0; i < 128; i++) stim[i] = $urandom;
        do_load_req();
        send_words(10, 0, 1'b0, lc);
        @(negedge clk);
        load_req = 1'b0;
        ld_valid = 1'b0;
        rst      = 1'b1;
        ld_valid = 1'b1;
        @(negedge clk);
        m_cnt = 0;
        m_sum = '0;
        m_err = 1'b0;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_cnt", word_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ld_ready, 0);
        chk("mid_rst_hold", cpu_hold, 1);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_ready", ld_ready, 0);
            chk("post_rst_busy", busy, 0);
        end
        ld_valid = 1'b0;

        // Recovery: a normal load from IDLE after the abandoned one.
        for (int i = 0; i < 128; i++) stim[i] = $urandom;
        web = n_we; stb = n_start;
        do_load_req();
        send_words(5, 30, 1'b1, lc);
        finish_load(lc, web, stb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
